// File: rtl/vga_cell_scanner_pkg.sv
// rtl/vga_cell_scanner_pkg.sv - shared VGA 640x480@60 timing, cell grid and color definitions
package vga_cell_scanner_pkg;

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FRONT      = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BACK       = 10'd48;
  localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;
  localparam logic [9:0] H_VIS_LAST   = H_VISIBLE - 10'd1;

  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FRONT      = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BACK       = 10'd33;
  localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;
  localparam logic [9:0] V_VIS_LAST   = V_VISIBLE - 10'd1;

  localparam int GRID_CELLS_X = 16;
  localparam int GRID_CELLS_Y = 12;
  localparam int GRID_CELL_PX = 40;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       visible;
    logic [2:0] rgb;
  } pixel_out_t;

  function automatic logic [2:0] cell_pixel(input logic visible, input logic on_grid,
                                            input logic [2:0] color);
    if (!visible)     return COLOR_BLACK;
    else if (on_grid) return COLOR_WHITE;
    else              return color;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// rtl/vga_sync_counter.sv - pixel tick divider, hCount/vCount and raw sync/visible decode
// The first tick after reset only primes the read port; counting starts on the second.
module vga_sync_counter
  import vga_cell_scanner_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  output logic       step,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       visible_raw
);

  logic [1:0] div;
  logic       tick;
  logic       primed;

  assign tick = (div == 2'(CLK_DIV - 1));
  assign step = tick & primed;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      div    <= 2'd0;
      primed <= 1'b0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      div <= tick ? 2'd0 : div + 2'd1;
      if (tick) primed <= 1'b1;
      if (step) begin
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
      end
    end
  end

  assign visible_raw = (hcount < H_VISIBLE) && (vcount < V_VISIBLE);
  assign hsync_raw   = !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
  assign vsync_raw   = !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));

endmodule

// File: rtl/vga_cell_scanner.sv
// rtl/vga_cell_scanner.sv - scans the 16x12 cell framebuffer and drives VGA sync/RGB
// Define VGA_GRID_EN to overlay 1-pixel white cell grid lines.
module vga_cell_scanner
  import vga_cell_scanner_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CELLS_X = GRID_CELLS_X,
  parameter int CELLS_Y = GRID_CELLS_Y,
  parameter int CELL_PX = GRID_CELL_PX
) (
  input  logic       Clock,
  input  logic       Reset,
  output logic [7:0] oReadAddress,
  input  logic [2:0] iReadColor,
  output logic       oHSync,
  output logic       oVSync,
  output logic       oRed,
  output logic       oGreen,
  output logic       oBlue,
  output logic       oVisible,
  output logic       oFrameStart
);

  localparam int SUB_W = $clog2(CELL_PX);
  localparam int COL_W = $clog2(CELLS_X);
  localparam int ROW_W = $clog2(CELLS_Y);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);

  logic             step;
  logic [9:0]       hcount, vcount;
  logic             hsync_raw, vsync_raw, visible_raw;
  logic [SUB_W-1:0] hsub, vsub;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             on_grid;
  pixel_out_t       pix_d, pix_q;

  vga_sync_counter #(.CLK_DIV(CLK_DIV)) u_sync (
    .Clock      (Clock),
    .Reset      (Reset),
    .step       (step),
    .hcount     (hcount),
    .vcount     (vcount),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .visible_raw(visible_raw)
  );

  // Cell counters freeze at the last visible cell so the address holds through blanking.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hsub <= '0;
      col  <= '0;
      vsub <= '0;
      row  <= '0;
    end else if (step) begin
      if (hcount == H_LAST) begin
        if (vcount == V_LAST) begin
          hsub <= '0;
          col  <= '0;
          vsub <= '0;
          row  <= '0;
        end else if (vcount < V_VIS_LAST) begin
          hsub <= '0;
          col  <= '0;
          if (vsub == SUB_LAST) begin
            vsub <= '0;
            row  <= row + 1'b1;
          end else begin
            vsub <= vsub + 1'b1;
          end
        end
      end else if ((hcount < H_VIS_LAST) && (vcount < V_VISIBLE)) begin
        if (hsub == SUB_LAST) begin
          hsub <= '0;
          col  <= col + 1'b1;
        end else begin
          hsub <= hsub + 1'b1;
        end
      end
    end
  end

  assign oReadAddress = 8'(row) * 8'(CELLS_X) + 8'(col);

`ifdef VGA_GRID_EN
  assign on_grid = (hsub == '0) || (vsub == '0);
`else
  assign on_grid = 1'b0;
`endif

  always_comb begin
    pix_d         = '0;
    pix_d.hsync   = hsync_raw;
    pix_d.vsync   = vsync_raw;
    pix_d.visible = visible_raw;
    pix_d.rgb     = cell_pixel(visible_raw, on_grid, iReadColor);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pix_q       <= '{hsync: 1'b1, vsync: 1'b1, visible: 1'b0, rgb: COLOR_BLACK};
      oFrameStart <= 1'b0;
    end else begin
      oFrameStart <= step && (hcount == '0) && (vcount == '0);
      if (step) pix_q <= pix_d;
    end
  end

  assign oHSync                 = pix_q.hsync;
  assign oVSync                 = pix_q.vsync;
  assign oVisible               = pix_q.visible;
  assign {oRed, oGreen, oBlue}  = pix_q.rgb;

endmodule

// File: tb/tb_vga_cell_scanner.sv
// tb/tb_vga_cell_scanner.sv - self-checking bench for vga_cell_scanner (honours VGA_GRID_EN)
module tb_vga_cell_scanner;

  localparam int LINES_A = 42;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] oReadAddress;
  logic [2:0] iReadColor;
  logic       oHSync, oVSync, oRed, oGreen, oBlue, oVisible, oFrameStart;

  logic [2:0] fb [192];
  bit         force_ones = 1'b0;
  logic [2:0] cap_rgb [LINES_A*800];
  logic       cap_vis [LINES_A*800];
  int         n_cmp = 0;
  int         n_bad = 0;

  typedef struct {
    int         h;
    int         v;
    logic       vis;
    logic [2:0] rgb_plain;
    logic [2:0] rgb_grid;
  } vec_t;
  vec_t tbl [13];

  always #5 Clock = ~Clock;

  // Synchronous-read framebuffer: color valid one Clock after the address.
  always @(posedge Clock)
    iReadColor <= force_ones ? 3'b111 : ((oReadAddress < 8'd192) ? fb[oReadAddress] : 3'b000);

  vga_cell_scanner #(.CLK_DIV(2)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .oReadAddress(oReadAddress),
    .iReadColor  (iReadColor),
    .oHSync      (oHSync),
    .oVSync      (oVSync),
    .oRed        (oRed),
    .oGreen      (oGreen),
    .oBlue       (oBlue),
    .oVisible    (oVisible),
    .oFrameStart (oFrameStart)
  );

  function automatic int cell_of(input int h, input int v);
    return (v / 40) * 16 + h / 40;
  endfunction

  function automatic logic [7:0] exp_addr(input int h, input int v);
    if (v >= 480) return 8'd191;
    if (h >= 640) return 8'(cell_of(639, v));
    return 8'(cell_of(h, v));
  endfunction

  function automatic logic [2:0] exp_rgb(input int h, input int v);
    if (!(h < 640 && v < 480)) return 3'b000;
`ifdef VGA_GRID_EN
    if ((h % 40 == 0) || (v % 40 == 0)) return 3'b111;
`endif
    if (force_ones) return 3'b111;
    return fb[cell_of(h, v)];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {oHSync, oVSync, oRed, oGreen, oBlue, oVisible, oFrameStart, oReadAddress},
          {1'b1, 1'b1, 5'b0, 8'h00});
  endtask

  task automatic do_reset(input int hold);
    @(negedge Clock);
    #2 Reset = 1'b0;
    #1 check_reset_outputs("reset_async");
    for (int i = 0; i < hold; i++) begin
      @(negedge Clock);
      check_reset_outputs("reset_held");
    end
    Reset = 1'b1;
  endtask

  task automatic wait_frame_start(input string name);
    int clks;
    clks = 0;
    while (oFrameStart !== 1'b1 && clks < 50) begin
      @(negedge Clock);
      clks++;
    end
    check(name, clks, 4);
  endtask

  task automatic scan(input int lines, input bit capture, input int wr_n,
                      input int wr_cell, input logic [2:0] wr_col);
    int         hs_low;
    int         h, v, hn, vn;
    logic [14:0] act, expv;
    hs_low = 0;
    for (int n = 0; n < lines * 800; n++) begin
      h  = n % 800;
      v  = n / 800;
      hn = (n + 1) % 800;
      vn = (n + 1) / 800;
      if (n == wr_n) fb[wr_cell] = wr_col;
      act  = {oHSync, oVSync, oVisible, oRed, oGreen, oBlue, oFrameStart, oReadAddress};
      expv = {!(h >= 656 && h < 752), !(v >= 490 && v < 492), (h < 640 && v < 480),
              exp_rgb(h, v), (n == 0), exp_addr(hn, vn)};
      n_cmp++;
      if (act !== expv) begin
        n_bad++;
        $display("FAIL pixel h=%0d v=%0d: got %b expected %b", h, v, act, expv);
      end
      if (!oHSync) hs_low++;
      if (capture) begin
        cap_rgb[n] = {oRed, oGreen, oBlue};
        cap_vis[n] = oVisible;
      end
      @(negedge Clock);
      @(negedge Clock);
    end
    check("hsync_low_ticks", hs_low, 96 * lines);
  endtask

  initial begin
    logic [2:0] exp_c;
    tbl[0]  = '{45,  0,  1'b1, 3'd1, 3'd7};
    tbl[1]  = '{0,   40, 1'b1, 3'd0, 3'd7};
    tbl[2]  = '{639, 0,  1'b1, 3'd7, 3'd7};
    tbl[3]  = '{40,  40, 1'b1, 3'd5, 3'd7};
    tbl[4]  = '{79,  41, 1'b1, 3'd5, 3'd5};
    tbl[5]  = '{80,  40, 1'b1, 3'd2, 3'd7};
    tbl[6]  = '{640, 0,  1'b0, 3'd0, 3'd0};
    tbl[7]  = '{799, 10, 1'b0, 3'd0, 3'd0};
    tbl[8]  = '{0,   0,  1'b1, 3'd0, 3'd7};
    tbl[9]  = '{39,  39, 1'b1, 3'd0, 3'd0};
    tbl[10] = '{40,  0,  1'b1, 3'd1, 3'd7};
    tbl[11] = '{600, 39, 1'b1, 3'd7, 3'd7};
    tbl[12] = '{41,  1,  1'b1, 3'd1, 3'd1};

    for (int i = 0; i < 192; i++) fb[i] = 3'(i % 8);
    fb[17] = 3'd2;

    // Phase A: power-on reset, then 42 lines with cell 17 rewritten during row 0.
    repeat (3) @(negedge Clock);
    check_reset_outputs("reset_initial");
    Reset = 1'b1;
    wait_frame_start("frame_start_latency_a");
    scan(LINES_A, 1'b1, 5 * 800, 17, 3'd5);
    for (int i = 0; i < 13; i++) begin
`ifdef VGA_GRID_EN
      exp_c = tbl[i].rgb_grid;
`else
      exp_c = tbl[i].rgb_plain;
`endif
      check($sformatf("table_rgb(%0d,%0d)", tbl[i].h, tbl[i].v),
            cap_rgb[tbl[i].v * 800 + tbl[i].h], exp_c);
      check($sformatf("table_vis(%0d,%0d)", tbl[i].h, tbl[i].v),
            cap_vis[tbl[i].v * 800 + tbl[i].h], tbl[i].vis);
    end

    // Phase B: mid-line reset, color input stuck at white.
    repeat ($urandom_range(100, 900)) @(negedge Clock);
    force_ones = 1'b1;
    do_reset(5);
    wait_frame_start("frame_start_latency_b");
    scan(2, 1'b0, -1, 0, 3'd0);

    // Phase C: random framebuffer with a random row-0 write ahead of the beam.
    force_ones = 1'b0;
    for (int i = 0; i < 192; i++) fb[i] = 3'($urandom);
    do_reset(2);
    wait_frame_start("frame_start_latency_c");
    scan(2, 1'b0, $urandom_range(0, 300), $urandom_range(10, 15), 3'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
